uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
- Parametrised successor to the fixed 8N1 serial receiver.
- Generalises data width, oversample ratio, parity and stop-bit count.
- Adds input synchronisation, false-start rejection, 3-sample majority voting, and a holding register with ack/overrun.
- Adds parity and framing error reporting.
- Sits between the board RX pin and the UART peripheral register block (uart_con status/data).

Parameters:
- DATA_BITS, 8: payload bits per frame, 5..9, LSB first.
- OVERSAMPLE, 16: sample_en ticks per bit period; even, 8..64.
- PARITY_MODE, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_en  in  1  oversample tick, OVERSAMPLE per bit; all bit timing advances only on clk edges with sample_en=1.
- uart_rx  in  1  asynchronous serial line, idle high.
- rx_data  out  DATA_BITS  last received payload, held until the next frame completes.
- rx_valid  out  1  one-clk pulse when a frame completes.
- rx_full  out  1  holding register has unread data.
- rd_ack  in  1  consumer read; clears rx_full.
- parity_err  out  1  parity mismatch on the frame in rx_data.
- frame_err  out  1  a stop bit sampled low on the frame in rx_data.
- overrun  out  1  sticky; a frame completed while rx_full=1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state, including mid-frame):
  - rx_data = all ones.
  - rx_valid, rx_full, parity_err, frame_err, overrun, busy = 0.
  - FSM = IDLE; counters = 0.
  - Synchroniser flops = 1.
- Synchroniser: uart_rx passes through 2 flops on every clk, independent of sample_en. A third flop holds the previous synchronised value for edge detection.
- Voting: a shift register holds the last 3 synchronised values captured on sample_en ticks. "Bit value" = majority of those 3.
- Within-bit phase counter: counts 0..OVERSAMPLE-1 on sample_en. MID = OVERSAMPLE/2.
- IDLE:
  - A synchronised 1->0 transition on a sample_en tick -> START; phase = 1.
- START:
  - At phase = MID: if bit value = 1 (false start) -> IDLE, nothing reported.
  - Otherwise, at phase wrap -> DATA; bit index = 0.
- DATA:
  - At phase = MID, the bit value shifts into bit [index] of the shadow register.
  - At phase wrap after index = DATA_BITS-1 -> PARITY if PARITY_MODE != 0, else STOP.
- PARITY:
  - At MID, compute the expected parity: XOR of the shadow register, inverted for odd.
  - A mismatch latches a local perr flag.
  - At wrap -> STOP.
- STOP:
  - At MID of each stop bit, a bit value of 0 sets a local ferr flag.
  - At MID of the final stop bit the frame completes, with no wait for phase wrap:
    - rx_data <= shadow; parity_err <= perr; frame_err <= ferr.
    - rx_valid = 1 for exactly the next clk cycle.
    - rx_full <= 1; if rx_full was already 1 and not being acked this cycle, overrun <= 1.
    - FSM -> IDLE; perr/ferr cleared.
  - Returning to IDLE at mid-stop allows back-to-back frames to start on the next falling edge.
- Overwrite and error status:
  - The new frame always overwrites rx_data; the newest data wins.
  - Error flags describe only the frame currently in rx_data.
- rd_ack:
  - Clears rx_full in the next cycle.
  - Simultaneous completion and rd_ack: rx_full stays 1 and overrun is not set.
  - rd_ack with rx_full = 0 is ignored.
  - overrun is cleared only by reset.
- Break condition (line held low):
  - The frame completes with frame_err = 1 and rx_data = 0.
  - The FSM then waits in IDLE for a rising edge followed by a falling edge; no repeated frames are produced.
- sample_en = 0: state is frozen except the synchroniser and the rx_valid pulse clear.
- Latency: rx_valid rises 3 clk cycles + (bit time × frame length − OVERSAMPLE/2 ticks) after the start edge at the pin.

Test Plan:
- Defaults, sample_en = 1, frame 0x5A 8N1 at 16 clk/bit -> one rx_valid pulse; rx_data = 0x5A; rx_full = 1; parity_err = frame_err = 0; busy low after mid-stop.
- 4-clk low glitch on an idle line -> no rx_valid; FSM returns to IDLE; busy = 0 by tick MID+1.
- PARITY_MODE = 2, frame 0x03 with parity bit 1 -> rx_data = 0x03; parity_err = 1. Repeat with parity bit 0 -> parity_err = 0.
- STOP_BITS = 2, second stop bit driven low -> frame_err = 1; rx_data still captured (0xA5 sent -> 0xA5).
- Two back-to-back frames 0x11, 0x22, no rd_ack -> rx_data = 0x22; overrun = 1. Repeat with rd_ack pulsed exactly on the completion cycle of the second frame -> overrun = 0; rx_full = 1.
- Assert reset mid-DATA of frame 0xFF -> all outputs at reset values immediately; the next clean frame 0x3C is received correctly. Also cover DATA_BITS = 7, OVERSAMPLE = 8 with 0x55 -> rx_data = 0x55.

Source files
------------

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling serial receiver. It synchronises the RX line, takes a
// 3-sample majority vote for each bit and rejects false starts. It checks parity and
// stop bits, and keeps the result in a holding register with ack and a sticky overrun.
//
// state  | meaning
// IDLE   | line idle, waiting for a synchronised falling edge on a tick
// START  | inside start bit; mid-bit vote confirms or rejects it
// DATA   | sampling payload bits LSB first into the shadow register
// PARITY | sampling the parity bit and comparing with the shadow XOR
// STOP   | sampling stop bit(s); frame completes at mid of the last one
module uart_rx_frame #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_full,
  input  logic                 rd_ack,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int              PH_W      = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] MID       = PH_W'(OVERSAMPLE / 2);
  localparam logic [PH_W-1:0] WRAP      = PH_W'(OVERSAMPLE - 1);
  localparam logic [3:0]      LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]      LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic            ODD       = (PARITY_MODE == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state, state_nxt;
  logic                   sync1, sync2, prev;
  logic [2:0]             vote;
  logic [PH_W-1:0]        phase;
  logic [3:0]             idx;
  logic [DATA_BITS-1:0]   shadow;
  logic                   perr, ferr;
  logic                   bit_val, exp_par, at_mid, at_wrap;
  logic                   start_hit, shift_bit, par_chk, stop_chk, complete;
  logic                   idx_clr, idx_inc;

  assign bit_val = (vote[0] & vote[1]) | (vote[0] & vote[2]) | (vote[1] & vote[2]);
  assign exp_par = (^shadow) ^ ODD;
  assign at_mid  = (phase == MID);
  assign at_wrap = (phase == WRAP);
  assign busy    = (state != IDLE);

  // State register; only moves on oversample ticks
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          state <= IDLE;
    else if (sample_en) state <= state_nxt;
  end

  // Next-state and per-tick control strobes
  always_comb begin
    state_nxt = state;
    start_hit = 1'b0;
    shift_bit = 1'b0;
    par_chk   = 1'b0;
    stop_chk  = 1'b0;
    complete  = 1'b0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    if (sample_en) begin
      case (state)
        IDLE: begin
          if (prev && !sync2) begin
            state_nxt = START;
            start_hit = 1'b1;
          end
        end
        START: begin
          if (at_mid && bit_val) begin
            state_nxt = IDLE;
          end else if (at_wrap) begin
            state_nxt = DATA;
            idx_clr   = 1'b1;
          end
        end
        DATA: begin
          if (at_mid) shift_bit = 1'b1;
          if (at_wrap) begin
            if (idx == LAST_DATA) begin
              state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
              idx_clr   = 1'b1;
            end else begin
              idx_inc = 1'b1;
            end
          end
        end
        PARITY: begin
          if (at_mid) par_chk = 1'b1;
          if (at_wrap) begin
            state_nxt = STOP;
            idx_clr   = 1'b1;
          end
        end
        STOP: begin
          if (at_mid) begin
            stop_chk = 1'b1;
            if (idx == LAST_STOP) begin
              complete  = 1'b1;
              state_nxt = IDLE;
            end
          end else if (at_wrap) begin
            idx_inc = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Two-flop synchroniser runs every clock; edge history and vote window advance on ticks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
      vote  <= 3'b111;
    end else begin
      sync1 <= uart_rx;
      sync2 <= sync1;
      if (sample_en) begin
        prev <= sync2;
        vote <= {vote[1:0], sync2};
      end
    end
  end

  // Bit-phase and bit-index counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
      idx   <= '0;
    end else if (sample_en) begin
      if (start_hit)                                          phase <= PH_W'(1);
      else if (state == IDLE || state_nxt == IDLE || at_wrap) phase <= '0;
      else                                                    phase <= phase + PH_W'(1);
      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + 4'd1;
    end
  end

  // Shadow shift, per-frame error flags and holding-register update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow     <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      rx_data    <= '1;
      rx_valid   <= 1'b0;
      rx_full    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_valid <= complete;
      if (complete)    rx_full <= 1'b1;
      else if (rd_ack) rx_full <= 1'b0;
      if (complete && rx_full && !rd_ack) overrun <= 1'b1;
      // LSB arrives first, so after DATA_BITS right-shifts it sits in bit 0
      if (shift_bit) shadow <= {bit_val, shadow[DATA_BITS-1:1]};
      if (par_chk && (bit_val != exp_par)) perr <= 1'b1;
      if (stop_chk && !bit_val) ferr <= 1'b1;
      if (complete) begin
        rx_data    <= shadow;
        parity_err <= perr;
        frame_err  <= ferr | ~bit_val;
        perr       <= 1'b0;
        ferr       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: three instances (default 8N1/16x, even parity with
// two stop bits, 7-bit payload at 8x) driven on separate RX lines.
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_en;
  logic       half_rate;
  logic       rx0, rx1, rx2;
  logic       ack0, ack1, ack2;
  logic [7:0] data0, data1;
  logic [6:0] data2;
  logic       valid0, full0, pe0, fe0, ov0, busy0;
  logic       valid1, full1, pe1, fe1, ov1, busy1;
  logic       valid2, full2, pe2, fe2, ov2, busy2;
  int         n_vec = 0;
  int         n_bad = 0;
  int         vc0 = 0, vc1 = 0, vc2 = 0;
  int         base;

  always #5 clk = ~clk;

  uart_rx_frame d0 (
    .clk(clk), .reset(reset), .sample_en(sample_en), .uart_rx(rx0),
    .rx_data(data0), .rx_valid(valid0), .rx_full(full0), .rd_ack(ack0),
    .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(busy0));

  uart_rx_frame #(.PARITY_MODE(2), .STOP_BITS(2)) d1 (
    .clk(clk), .reset(reset), .sample_en(sample_en), .uart_rx(rx1),
    .rx_data(data1), .rx_valid(valid1), .rx_full(full1), .rd_ack(ack1),
    .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(busy1));

  uart_rx_frame #(.DATA_BITS(7), .OVERSAMPLE(8)) d2 (
    .clk(clk), .reset(reset), .sample_en(sample_en), .uart_rx(rx2),
    .rx_data(data2), .rx_valid(valid2), .rx_full(full2), .rd_ack(ack2),
    .parity_err(pe2), .frame_err(fe2), .overrun(ov2), .busy(busy2));

  // Count rx_valid pulses per instance
  always @(negedge clk) begin
    if (valid0) vc0++;
    if (valid1) vc1++;
    if (valid2) vc2++;
  end

  // Tick generator: every clock, or every other clock when half_rate is set
  initial begin
    sample_en = 1'b1;
    forever begin
      @(posedge clk);
      #1 sample_en = half_rate ? ~sample_en : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, n_bad=%0d", n_bad);
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_line(input int inst, input logic v);
    case (inst)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic drive(input int inst, input logic v, input int cpb);
    set_line(inst, v);
    repeat (cpb) @(posedge clk);
    #1;
  endtask

  // par < 0: no parity bit; stops[i] is the level of stop bit i
  task automatic send(input int inst, input logic [8:0] d, input int nbits, input int par,
                      input int nstop, input logic [1:0] stops, input int cpb);
    drive(inst, 1'b0, cpb);
    for (int i = 0; i < nbits; i++) drive(inst, d[i], cpb);
    if (par >= 0) drive(inst, par[0], cpb);
    for (int i = 0; i < nstop; i++) drive(inst, stops[i], cpb);
    set_line(inst, 1'b1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; half_rate = 1'b0;
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    ack0 = 1'b0; ack1 = 1'b0; ack2 = 1'b0;
    settle(3);
    chk("rst_data0", 32'(data0), 32'hff);
    chk("rst_flags0", 32'({valid0, full0, pe0, fe0, ov0, busy0}), 0);
    chk("rst_data2", 32'(data2), 32'h7f);
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) @(posedge clk); #1;

    // Basic 8N1 frame
    base = vc0;
    send(0, 9'h05a, 8, -1, 1, 2'b11, 16);
    settle(4);
    chk("5a_pulses", 32'(vc0 - base), 1);
    chk("5a_data", 32'(data0), 32'h5a);
    chk("5a_full", 32'(full0), 1);
    chk("5a_errs", 32'({pe0, fe0}), 0);
    chk("5a_busy", 32'(busy0), 0);

    ack0 = 1'b1; @(posedge clk); #1 ack0 = 1'b0;
    settle(1);
    chk("ack_clears_full", 32'(full0), 0);
    chk("ack_keeps_data", 32'(data0), 32'h5a);

    // Four-clock glitch: START entered, then rejected at mid-bit
    base = vc0;
    rx0 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx0 = 1'b1;
    @(posedge clk); #1;
    chk("glitch_busy_hi", 32'(busy0), 1);
    repeat (8) @(posedge clk); #1;
    chk("glitch_busy_lo", 32'(busy0), 0);
    settle(200);
    chk("glitch_no_pulse", 32'(vc0 - base), 0);
    chk("glitch_full", 32'(full0), 0);

    // Back-to-back with rd_ack exactly on the second completion cycle.
    // Frames are 160 clocks apart, so second completion is 160 edges after the first.
    base = vc0;
    fork
      begin
        send(0, 9'h011, 8, -1, 1, 2'b11, 16);
        send(0, 9'h022, 8, -1, 1, 2'b11, 16);
      end
      begin
        int k;
        k = 0;
        while (!valid0 && k < 400) begin
          @(negedge clk);
          k++;
        end
        chk("b2b_first_seen", 32'(k < 400), 1);
        if (k < 400) begin
          repeat (159) @(posedge clk);
          #1 ack0 = 1'b1;
          @(posedge clk);
          #1 ack0 = 1'b0;
        end
      end
    join
    settle(10);
    chk("ackb2b_pulses", 32'(vc0 - base), 2);
    chk("ackb2b_data", 32'(data0), 32'h22);
    chk("ackb2b_overrun", 32'(ov0), 0);
    chk("ackb2b_full", 32'(full0), 1);

    // Back-to-back with no ack: overrun
    base = vc0;
    send(0, 9'h011, 8, -1, 1, 2'b11, 16);
    send(0, 9'h022, 8, -1, 1, 2'b11, 16);
    settle(4);
    chk("ovr_pulses", 32'(vc0 - base), 2);
    chk("ovr_data", 32'(data0), 32'h22);
    chk("ovr_overrun", 32'(ov0), 1);
    chk("ovr_full", 32'(full0), 1);

    // Reset in the middle of the data bits of 0xFF
    drive(0, 1'b0, 16);
    drive(0, 1'b1, 40);
    chk("mid_busy", 32'(busy0), 1);
    reset = 1'b1;
    #2;
    chk("mid_rst_data", 32'(data0), 32'hff);
    chk("mid_rst_flags", 32'({valid0, full0, pe0, fe0, ov0, busy0}), 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (200) @(posedge clk); #1;
    base = vc0;
    send(0, 9'h03c, 8, -1, 1, 2'b11, 16);
    settle(4);
    chk("3c_pulses", 32'(vc0 - base), 1);
    chk("3c_data", 32'(data0), 32'h3c);
    chk("3c_errs", 32'({pe0, fe0, ov0}), 0);

    // Tick on every other clock: 32 clocks per bit
    half_rate = 1'b1;
    repeat (20) @(posedge clk); #1;
    base = vc0;
    send(0, 9'h096, 8, -1, 1, 2'b11, 32);
    settle(8);
    half_rate = 1'b0;
    chk("half_pulses", 32'(vc0 - base), 1);
    chk("half_data", 32'(data0), 32'h96);
    chk("half_overrun", 32'(ov0), 1);

    // Even parity, two stop bits
    send(1, 9'h003, 8, 1, 2, 2'b11, 16);
    settle(4);
    chk("par1_data", 32'(data1), 32'h03);
    chk("par1_perr", 32'(pe1), 1);
    chk("par1_ferr", 32'(fe1), 0);
    send(1, 9'h003, 8, 0, 2, 2'b11, 16);
    settle(4);
    chk("par0_perr", 32'(pe1), 0);
    send(1, 9'h007, 8, 1, 2, 2'b11, 16);
    settle(4);
    chk("par07_perr", 32'(pe1), 0);
    chk("par07_data", 32'(data1), 32'h07);
    send(1, 9'h0a5, 8, 0, 2, 2'b01, 16);
    settle(4);
    chk("stop2_data", 32'(data1), 32'ha5);
    chk("stop2_ferr", 32'(fe1), 1);
    chk("stop2_perr", 32'(pe1), 0);
    chk("d1_pulses", 32'(vc1), 4);

    // 7 data bits at 8x oversample
    send(2, 9'h055, 7, -1, 1, 2'b11, 8);
    settle(4);
    chk("d7_pulses", 32'(vc2), 1);
    chk("d7_data", 32'(data2), 32'h55);
    chk("d7_ferr", 32'(fe2), 0);

    // Break: exactly one frame with frame_err and zero data
    drive(2, 1'b0, 200);
    set_line(2, 1'b1);
    settle(20);
    chk("brk_pulses", 32'(vc2), 2);
    chk("brk_data", 32'(data2), 0);
    chk("brk_ferr", 32'(fe2), 1);
    send(2, 9'h02a, 7, -1, 1, 2'b11, 8);
    settle(4);
    chk("after_brk_pulses", 32'(vc2), 3);
    chk("after_brk_data", 32'(data2), 32'h2a);
    chk("after_brk_ferr", 32'(fe2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
